sat_counter_bank: RTL and testbench



---
 rtl/sat_counter_bank.sv | 108 ++++++++++
 tb/tb_sat_counter_bank.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sat_counter_bank.sv
// Bank of DEPTH saturating up/down counters with one update port and one registered,
// write-first read port. Define SAT_COUNTER_STATS_EN to add the sat_events counter.

module sat_counter_bank_cell #(
    parameter int WIDTH    = 2,
    parameter int INIT_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             upd,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_nxt,
    output logic             sat_hit
);
    localparam logic [WIDTH-1:0] INIT = WIDTH'(INIT_VAL);

    logic at_max, at_min;

    assign at_max  = &count;
    assign at_min  = ~|count;
    assign sat_hit = upd & (dir ? at_max : at_min);

    // count_nxt doubles as the bypass value for a same-cycle read
    always_comb begin
        count_nxt = count;
        if (clr)
            count_nxt = INIT;
        else if (upd && !sat_hit)
            count_nxt = dir ? count + 1'b1 : count - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= INIT;
        else     count <= count_nxt;
    end
endmodule

module sat_counter_bank #(
    parameter int WIDTH    = 2,
    parameter int DEPTH    = 16,
    parameter int INIT_VAL = 0,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_dir,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
`ifdef SAT_COUNTER_STATS_EN
    output logic [15:0]      sat_events,
`endif
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_count,
    output logic             rd_taken
);
    logic [DEPTH-1:0][WIDTH-1:0] count;
    logic [DEPTH-1:0][WIDTH-1:0] count_nxt;
    logic [DEPTH-1:0]            sat_hit;
    logic [DEPTH-1:0]            upd_sel;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        assign upd_sel[i] = upd_en & ~clr & (upd_idx == IDX_W'(i));

        sat_counter_bank_cell #(
            .WIDTH    (WIDTH),
            .INIT_VAL (INIT_VAL)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .upd       (upd_sel[i]),
            .dir       (upd_dir),
            .count     (count[i]),
            .count_nxt (count_nxt[i]),
            .sat_hit   (sat_hit[i])
        );
    end

    // Read the next-state value so a same-cycle update or clear is visible (write-first)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_count <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_count <= count_nxt[rd_idx];
        end
    end

    assign rd_taken = rd_count[WIDTH-1];

`ifdef SAT_COUNTER_STATS_EN
    // Sticky at all-ones rather than wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_events <= '0;
        else if (clr)
            sat_events <= '0;
        else if (|sat_hit && sat_events != 16'hFFFF)
            sat_events <= sat_events + 16'd1;
    end
`endif
endmodule

// File: tb/tb_sat_counter_bank.sv
// Directed self-checking bench for sat_counter_bank (WIDTH=2, DEPTH=16, INIT_VAL=0).

module tb_sat_counter_bank;
    logic       clk = 1'b0;
    logic       rst, clr, upd_en, upd_dir, rd_en;
    logic [3:0] upd_idx, rd_idx;
    logic       rd_valid, rd_taken;
    logic [1:0] rd_count;
`ifdef SAT_COUNTER_STATS_EN
    logic [15:0] sat_events;
`endif
    int checks = 0;
    int errors = 0;

    sat_counter_bank #(.WIDTH(2), .DEPTH(16), .INIT_VAL(0)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .upd_en(upd_en), .upd_idx(upd_idx), .upd_dir(upd_dir),
        .rd_en(rd_en), .rd_idx(rd_idx),
`ifdef SAT_COUNTER_STATS_EN
        .sat_events(sat_events),
`endif
        .rd_valid(rd_valid), .rd_count(rd_count), .rd_taken(rd_taken)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic upd(input logic [3:0] idx, input logic dir);
        upd_en = 1'b1; upd_idx = idx; upd_dir = dir;
        cyc();
        upd_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] idx);
        rd_en = 1'b1; rd_idx = idx;
        cyc();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 0; upd_en = 0; upd_dir = 0; upd_idx = 0; rd_en = 0; rd_idx = 0;
        repeat (8) cyc();
        checks++;
        if (rd_valid !== 1'b0 || rd_count !== 2'd0 || rd_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b count=%0d taken=%b, want 0 0 0", rd_valid, rd_count, rd_taken);
        end
        rst = 1'b0;
        cyc();
        rd(4'd3);
        checks++;
        if (rd_valid !== 1'b1 || rd_count !== 2'd0 || rd_taken !== 1'b0) begin
            errors++;
            $display("FAIL first_read: got valid=%b count=%0d taken=%b, want 1 0 0", rd_valid, rd_count, rd_taken);
        end
    endtask

    task automatic test_count_up();
        logic [1:0] exp [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        for (int k = 0; k < 4; k++) begin
            upd(4'd5, 1'b1);
            rd(4'd5);
            checks++;
            if (rd_count !== exp[k] || rd_taken !== exp[k][1]) begin
                errors++;
                $display("FAIL count_up[%0d]: got count=%0d taken=%b, want %0d %b", k, rd_count, rd_taken, exp[k], exp[k][1]);
            end
        end
        // upd_en low must not move the counter
        upd_en = 1'b0; upd_dir = 1'b0; upd_idx = 4'd5;
        cyc();
        rd(4'd5);
        checks++;
        if (rd_count !== 2'd3) begin
            errors++;
            $display("FAIL upd_en_low: got %0d want 3", rd_count);
        end
`ifdef SAT_COUNTER_STATS_EN
        checks++;
        if (sat_events !== 16'd1) begin
            errors++;
            $display("FAIL sat_events_up: got %0d want 1", sat_events);
        end
`endif
    endtask

    task automatic test_count_down();
        logic [1:0] exp [4] = '{2'd2, 2'd1, 2'd0, 2'd0};
        for (int k = 0; k < 4; k++) begin
            upd(4'd5, 1'b0);
            rd(4'd5);
            checks++;
            if (rd_count !== exp[k] || rd_taken !== exp[k][1]) begin
                errors++;
                $display("FAIL count_down[%0d]: got count=%0d taken=%b, want %0d %b", k, rd_count, rd_taken, exp[k], exp[k][1]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            rd(4'(i));
            checks++;
            if (rd_count !== 2'd0) begin
                errors++;
                $display("FAIL others_zero[%0d]: got %0d want 0", i, rd_count);
            end
        end
    endtask

    task automatic test_bypass();
        upd(4'd7, 1'b1);
        upd_en = 1'b1; upd_idx = 4'd7; upd_dir = 1'b1;
        rd_en = 1'b1; rd_idx = 4'd7;
        cyc();
        upd_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_count !== 2'd2 || rd_taken !== 1'b1) begin
            errors++;
            $display("FAIL bypass_up: got valid=%b count=%0d, want 1 2", rd_valid, rd_count);
        end
        upd(4'd7, 1'b0);
        upd_en = 1'b1; upd_idx = 4'd7; upd_dir = 1'b0;
        rd_en = 1'b1; rd_idx = 4'd7;
        cyc();
        upd_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (rd_count !== 2'd0) begin
            errors++;
            $display("FAIL bypass_down: got %0d want 0", rd_count);
        end
    endtask

    task automatic test_clear();
        upd(4'd7, 1'b1);
        repeat (3) upd(4'd2, 1'b1);
        rd(4'd2);
        checks++;
        if (rd_count !== 2'd3) begin
            errors++;
            $display("FAIL clear_setup: got %0d want 3", rd_count);
        end
        clr = 1'b1; upd_en = 1'b1; upd_idx = 4'd2; upd_dir = 1'b1;
        rd_en = 1'b1; rd_idx = 4'd2;
        cyc();
        clr = 1'b0; upd_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_count !== 2'd0) begin
            errors++;
            $display("FAIL clear_priority: got valid=%b count=%0d, want 1 0", rd_valid, rd_count);
        end
        // rd_en low: valid drops, count holds
        cyc();
        checks++;
        if (rd_valid !== 1'b0 || rd_count !== 2'd0) begin
            errors++;
            $display("FAIL read_idle: got valid=%b count=%0d, want 0 0", rd_valid, rd_count);
        end
        rd(4'd2);
        checks++;
        if (rd_count !== 2'd0) begin
            errors++;
            $display("FAIL clear_after_idx2: got %0d want 0", rd_count);
        end
        rd(4'd7);
        checks++;
        if (rd_count !== 2'd0) begin
            errors++;
            $display("FAIL clear_after_idx7: got %0d want 0", rd_count);
        end
`ifdef SAT_COUNTER_STATS_EN
        checks++;
        if (sat_events !== 16'd0) begin
            errors++;
            $display("FAIL sat_events_clr: got %0d want 0", sat_events);
        end
`endif
    endtask

    task automatic test_async_reset();
        repeat (3) upd(4'd1, 1'b0);
`ifdef SAT_COUNTER_STATS_EN
        checks++;
        if (sat_events !== 16'd3) begin
            errors++;
            $display("FAIL sat_events_3: got %0d want 3", sat_events);
        end
`endif
        repeat (2) upd(4'd1, 1'b1);
        rd(4'd1);
        checks++;
        if (rd_valid !== 1'b1 || rd_count !== 2'd2) begin
            errors++;
            $display("FAIL pre_reset_read: got valid=%b count=%0d, want 1 2", rd_valid, rd_count);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rd_valid !== 1'b0 || rd_count !== 2'd0 || rd_taken !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b count=%0d taken=%b, want 0 0 0", rd_valid, rd_count, rd_taken);
        end
`ifdef SAT_COUNTER_STATS_EN
        checks++;
        if (sat_events !== 16'd0) begin
            errors++;
            $display("FAIL async_reset_events: got %0d want 0", sat_events);
        end
`endif
        rst = 1'b0;
        rd(4'd1);
        checks++;
        if (rd_count !== 2'd0) begin
            errors++;
            $display("FAIL post_reset_idx1: got %0d want 0", rd_count);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_bypass();
        test_clear();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
